seq_det_sched: RTL and testbench

- Time-multiplexes one shared 2-bit Mealy sequence-detector step across NCH serial-bit requesters.
- Keeps a private detector state per channel and grants one bit per cycle, round-robin.
- Returns the registered Mealy output tagged with the channel number.
- Sits between several serial input sources and downstream match logic, so one detector serves all streams.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_det_sched_if.sv | 28 ++
 rtl/seq_det_sched_mealy_step.sv | 17 +
 rtl/seq_det_sched.sv | 139 +++++++++++++
 tb/tb_seq_det_sched.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the time-multiplexed sequence detector.
// The step function is held as lookup constants indexed by {A,B,X}.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } state_t;

    localparam int NCH_DEF   = 4;
    localparam int CH_W_DEF  = 2;
    localparam int CNT_W_DEF = 8;

    // Bit k is Y for {A,B,X}=k; set for 2, 4 and 6.
    localparam logic [7:0]  Y_TBL    = 8'b0101_0100;
    // Two bits per {A,B,X} entry, entry 7 in the MSBs.
    localparam logic [15:0] NEXT_TBL = {S10, S00, S10, S00, S11, S00, S01, S00};

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester/result bundle for seq_det_sched; master drives requests, slave is the scheduler.
interface seq_det_sched_if
    import seq_det_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CH_W  = CH_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   bit_in;
    logic [NCH-1:0]   clr_ch;
    logic [NCH-1:0]   ack;
    logic             y_valid;
    logic [CH_W-1:0]  y_ch;
    logic             y;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_cnt;

    modport master (
        output req, bit_in, clr_ch, rd_ch,
        input  ack, y_valid, y_ch, y, rd_cnt
    );

    modport slave (
        input  req, bit_in, clr_ch, rd_ch,
        output ack, y_valid, y_ch, y, rd_cnt
    );
endinterface

// File: rtl/seq_det_sched_mealy_step.sv
// One combinational step of the 2-bit Mealy detector: (state, X) -> (next state, Y).
module mealy_step
    import seq_det_pkg::*;
(
    input  state_t state_i,
    input  logic   x_i,
    output state_t next_o,
    output logic   y_o
);
    logic [2:0] idx;

    always_comb begin
        idx    = {state_i, x_i};
        y_o    = Y_TBL[idx];
        next_o = state_t'(NEXT_TBL[{idx, 1'b0} +: 2]);
    end
endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one mealy_step across NCH serial channels.
// Optional per-channel match counters are built when MATCH_CNT_EN is defined.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CH_W  = CH_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    seq_det_sched_if.slave  bus
);
    state_t          state_q [NCH];
    state_t          state_d [NCH];
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] y_ch_q, y_ch_d;
    logic            y_q, y_d;
    logic            y_valid_q, y_valid_d;

    logic [NCH-1:0]  elig;
    logic [NCH-1:0]  ack;
    logic            gnt_vld;
    logic [CH_W-1:0] gnt;
    state_t          cur_st;
    logic            cur_x;
    state_t          nxt_st;
    logic            step_y;

    // A channel being cleared is never granted, so its pending bit stays put.
    assign elig = bus.req & ~bus.clr_ch;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt     = CH_W'(idx);
            end
        end
        if (rst) gnt_vld = 1'b0;
    end

    always_comb begin
        ack = '0;
        if (gnt_vld) ack[gnt] = 1'b1;
    end

    always_comb begin
        cur_st = state_q[gnt];
        cur_x  = bus.bit_in[gnt];
    end

    mealy_step u_step (
        .state_i (cur_st),
        .x_i     (cur_x),
        .next_o  (nxt_st),
        .y_o     (step_y)
    );

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            if (bus.clr_ch[i])
                state_d[i] = S00;
            else if (gnt_vld && gnt == CH_W'(i))
                state_d[i] = nxt_st;
        end
        rr_ptr_d  = rr_ptr_q;
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        y_valid_d = gnt_vld;
        if (gnt_vld) begin
            y_d      = step_y;
            y_ch_d   = gnt;
            rr_ptr_d = (gnt == CH_W'(NCH - 1)) ? '0 : gnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) state_q[i] <= S00;
            rr_ptr_q  <= '0;
            y_q       <= 1'b0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
            rr_ptr_q  <= rr_ptr_d;
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.ack     = ack;
    assign bus.y       = y_q;
    assign bus.y_ch    = y_ch_q;
    assign bus.y_valid = y_valid_q;

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.clr_ch[i])
                cnt_d[i] = '0;
            else if (gnt_vld && gnt == CH_W'(i) && step_y && cnt_q[i] != '1)
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Select values past the last channel read as zero.
    always_comb begin
        bus.rd_cnt = '0;
        if (int'(bus.rd_ch) < NCH) bus.rd_cnt = cnt_q[bus.rd_ch];
    end
`else
    logic unused_rd_ch;
    assign unused_rd_ch = ^bus.rd_ch;
    assign bus.rd_cnt   = '0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed table-driven bench for seq_det_sched plus a standalone mealy_step check.
module tb_seq_det_sched;
    import seq_det_pkg::*;

    localparam int NCH   = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 8;
    localparam int NROWS = 35;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    seq_det_sched_if #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    seq_det_sched #(.NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    state_t u_st;
    logic   u_x;
    state_t u_nxt;
    logic   u_y;

    mealy_step u_unit (
        .state_i (u_st),
        .x_i     (u_x),
        .next_o  (u_nxt),
        .y_o     (u_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] bit_in;
        logic [3:0] clr;
        logic [3:0] ack;
        logic       chk;
        logic       yv;
        logic       y;
        logic [1:0] ych;
    } vec_t;

    vec_t tbl [NROWS];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] b, logic [3:0] c,
                                logic [3:0] a, logic ck, logic v, logic yy, logic [1:0] ch);
        vec_t t;
        t.rst = r; t.req = rq; t.bit_in = b; t.clr = c; t.ack = a;
        t.chk = ck; t.yv = v; t.y = yy; t.ych = ch;
        return t;
    endfunction

    task automatic cmp(string name, int idx, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [1:0] nx_exp [8];
        logic [7:0] y_exp;
        int         acks;

        n_cmp = 0;
        n_bad = 0;
        rst        = 1'b1;
        bus.req    = '0;
        bus.bit_in = '0;
        bus.clr_ch = '0;
        bus.rd_ch  = '0;

        // Standalone step function: {A,B,X} -> next state, Y.
        nx_exp[0] = 2'b00; nx_exp[1] = 2'b01; nx_exp[2] = 2'b00; nx_exp[3] = 2'b11;
        nx_exp[4] = 2'b00; nx_exp[5] = 2'b10; nx_exp[6] = 2'b00; nx_exp[7] = 2'b10;
        y_exp = 8'b0101_0100;
        for (int i = 0; i < 8; i++) begin
            u_st = state_t'(i[2:1]);
            u_x  = i[0];
            #1;
            cmp("step", i, {5'd0, u_y, u_nxt}, {5'd0, y_exp[i], nx_exp[i]});
        end

        //             rst   req    bit    clr    ack   chk yv  y  ych
        tbl[0]  = mk(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        tbl[1]  = mk(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0);
        // single stream on ch0: bits 0,1,1,1,0
        tbl[2]  = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0);
        tbl[3]  = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1, 1, 0, 0);
        tbl[4]  = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1, 1, 0, 0);
        tbl[5]  = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1, 1, 0, 0);
        tbl[6]  = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1, 1, 0, 0);
        tbl[7]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 1, 0);
        tbl[8]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 1, 0);
        // round robin from rr_ptr=1, wrapping
        tbl[9]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h2, 1, 0, 1, 0);
        tbl[10] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h4, 1, 1, 0, 1);
        tbl[11] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h8, 1, 1, 0, 2);
        tbl[12] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 1, 1, 0, 3);
        tbl[13] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h2, 1, 1, 0, 0);
        tbl[14] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h4, 1, 1, 0, 1);
        tbl[15] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h8, 1, 1, 0, 2);
        tbl[16] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 1, 1, 0, 3);
        tbl[17] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0);
        // interleaved: ch1 gets 1,1,0 and ch2 gets 1,0
        tbl[18] = mk(1'b0, 4'h6, 4'h6, 4'h0, 4'h2, 1, 0, 0, 0);
        tbl[19] = mk(1'b0, 4'h6, 4'h6, 4'h0, 4'h4, 1, 1, 0, 1);
        tbl[20] = mk(1'b0, 4'h6, 4'h2, 4'h0, 4'h2, 1, 1, 0, 2);
        tbl[21] = mk(1'b0, 4'h6, 4'h0, 4'h0, 4'h4, 1, 1, 0, 1);
        tbl[22] = mk(1'b0, 4'h2, 4'h0, 4'h0, 4'h2, 1, 1, 1, 2);
        tbl[23] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 1, 1);
        // drive ch0 to state 11, then clear while it requests with bit 0
        tbl[24] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 1, 1);
        tbl[25] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'h1, 1, 1, 0, 0);
        tbl[26] = mk(1'b0, 4'h1, 4'h0, 4'h1, 4'h0, 1, 1, 0, 0);
        tbl[27] = mk(1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0);
        tbl[28] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0);
        // reset in the middle of a four-channel burst
        tbl[29] = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h2, 1, 0, 0, 0);
        tbl[30] = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h4, 1, 1, 0, 1);
        tbl[31] = mk(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1, 1, 0, 2);
        tbl[32] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h1, 1, 0, 0, 0);
        tbl[33] = mk(1'b0, 4'hF, 4'h0, 4'h0, 4'h2, 1, 1, 0, 0);
        tbl[34] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0, 1);

        @(posedge clk); #1;
        for (int r = 0; r < NROWS; r++) begin
            rst        = tbl[r].rst;
            bus.req    = tbl[r].req;
            bus.bit_in = tbl[r].bit_in;
            bus.clr_ch = tbl[r].clr;
            @(negedge clk);
            cmp("ack", r, {4'd0, bus.ack}, {4'd0, tbl[r].ack});
            if (tbl[r].chk)
                cmp("out", r, {4'd0, bus.y_valid, bus.y, bus.y_ch},
                    {4'd0, tbl[r].yv, tbl[r].y, tbl[r].ych});
            @(posedge clk); #1;
        end

`ifdef MATCH_CNT_EN
        // ch3 fed "10" 300 times: 300 matches saturate at 255
        rst = 1'b1; bus.req = '0; bus.bit_in = '0; bus.clr_ch = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        bus.req = 4'h8;
        for (int i = 0; i < 600; i++) begin
            bus.bit_in = (i % 2 == 0) ? 4'h8 : 4'h0;
            @(negedge clk);
            if (bus.ack == 4'h8) acks++;
            @(posedge clk); #1;
        end
        bus.req = '0;
        cmp("acks", 0, 8'(acks / 4), 8'd150);
        for (int c = 0; c < NCH; c++) begin
            bus.rd_ch = 2'(c);
            #1;
            cmp("cnt", c, bus.rd_cnt, (c == 3) ? 8'd255 : 8'd0);
        end
        bus.clr_ch = 4'h8;
        @(posedge clk); #1;
        bus.clr_ch = '0;
        bus.rd_ch  = 2'd3;
        #1;
        cmp("cnt_clr", 3, bus.rd_cnt, 8'd0);
`else
        acks = 0;
        for (int c = 0; c < NCH; c++) begin
            bus.rd_ch = 2'(c);
            #1;
            cmp("cnt_off", c + acks, bus.rd_cnt, 8'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
